// File: rtl/dsp_bus_pkg.sv
// Shared definitions for the 8-bit DSP parallel bus.
//   state_t      : bus master FSM state encoding
//   ADDR_W/DATA_W: bus address and data widths
//   CNT_W        : width of the phase down-counter
//   register map : responder addresses used by FPGA logic and bench self-test
//   cyc_load()   : converts a phase length in cycles into a counter preload
package dsp_bus_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    // Responder register map
    localparam logic [ADDR_W-1:0] IO_OUT      = 5'd19;
    localparam logic [ADDR_W-1:0] PULSE_TYPE  = 5'd20;
    localparam logic [ADDR_W-1:0] KEY         = 5'd2;
    localparam logic [ADDR_W-1:0] IO_IN       = 5'd3;
    localparam logic [ADDR_W-1:0] VERSION     = 5'd31;
    localparam logic [DATA_W-1:0] VERSION_VAL = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREP    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    // A phase of 0 cycles is stretched to 1; lengths above the counter range
    // saturate at 255. The counter counts down to 0, so the preload is len-1.
    function automatic logic [CNT_W-1:0] cyc_load(input int cyc);
        int eff;
        eff = (cyc < 1) ? 1 : ((cyc > 255) ? 255 : cyc);
        return CNT_W'(eff - 1);
    endfunction

endpackage

// File: rtl/dsp_bus_master.sv
// dsp_bus_master: initiator for the 8-bit DSP parallel bus.
// Converts single-word read/write requests into bus cycles with programmable
// phase lengths, timed for a responder that double-flops bus_cs/bus_we.
//
// Ports
//   clk_in       in     system clock (30 MHz)
//   rst_n_in     in     asynchronous active-low reset
//   req          in     request strobe, accepted only while ready=1
//   req_we       in     1=write, 0=read
//   req_addr     in     bus address
//   req_wdata    in     write data
//   ready        out    1 while idle
//   done         out    one-cycle pulse when the FSM returns to idle
//   rdata        out    last read data, held until the next read completes
//   bus_cs       out    chip select, active low
//   bus_we       out    write/read strobe
//   bus_address  out    bus address
//   bus_data     inout  driven only during the write SETUP/STROBE/HOLD phases
//   fsm_state    out    current FSM state (debug observation)
//
// Handshake: a request transfers on a rising clk_in edge where req=1 and
// ready=1; ready falls in the following cycle and rises again in the cycle
// done pulses. A req seen while ready=0 is dropped, never queued.
//
// Write: SETUP -> STROBE -> HOLD -> RECOVER -> IDLE
// Read : PREP -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE
module dsp_bus_master
    import dsp_bus_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int STROBE_CYC    = 6,
    parameter int READ_WAIT_CYC = 8,
    parameter int HOLD_CYC      = 2,
    parameter int RECOVER_CYC   = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_cs,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_address,
    inout  wire  [DATA_W-1:0] bus_data,
    output state_t            fsm_state
);

    localparam logic [CNT_W-1:0] L_SETUP     = cyc_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] L_STROBE    = cyc_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] L_READ_WAIT = cyc_load(READ_WAIT_CYC);
    localparam logic [CNT_W-1:0] L_HOLD      = cyc_load(HOLD_CYC);
    localparam logic [CNT_W-1:0] L_RECOVER   = cyc_load(RECOVER_CYC);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  load_val;
    logic              cnt_zero;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic              drive_en;
    logic              eff_we;

    assign cnt_zero  = (cnt == '0);
    assign fsm_state = state;

    // In IDLE the direction comes straight from the request being accepted;
    // afterwards it comes from the latched copy.
    assign eff_we = (state == ST_IDLE) ? req_we : lat_we;

    // Next state and the counter preload for the state being entered.
    always_comb begin
        next_state = state;
        load_val   = '0;
        case (state)
            ST_IDLE: begin
                if (req && ready) begin
                    next_state = req_we ? ST_SETUP : ST_PREP;
                    load_val   = L_SETUP;
                end
            end
            ST_PREP: begin
                if (cnt_zero) begin
                    next_state = ST_SETUP;
                    load_val   = L_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    next_state = ST_STROBE;
                    load_val   = lat_we ? L_STROBE : L_READ_WAIT;
                end
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    next_state = ST_HOLD;
                    load_val   = L_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    next_state = ST_RECOVER;
                    load_val   = L_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (cnt_zero) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Single phase counter: preloaded on every state change, otherwise counts
    // down and parks at zero.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= load_val;
        end else if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    // FSM with registered outputs. Outputs are decoded from next_state so
    // that they change on the same edge as the state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= ST_IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            rdata       <= '0;
            bus_cs      <= 1'b1;
            bus_we      <= 1'b0;
            bus_address <= '0;
            drive_en    <= 1'b0;
            lat_we      <= 1'b0;
            lat_wdata   <= '0;
        end else begin
            state <= next_state;
            ready <= (next_state == ST_IDLE);
            done  <= (state != ST_IDLE) && (next_state == ST_IDLE);

            if (state == ST_IDLE && req && ready) begin
                lat_we      <= req_we;
                lat_wdata   <= req_wdata;
                bus_address <= req_addr;
            end

            // Last STROBE cycle of a read: responder has been driving for
            // several cycles by now.
            if (state == ST_STROBE && !lat_we && cnt_zero) begin
                rdata <= bus_data;
            end

            // bus_we only moves while bus_cs=1 or on entry to STROBE. For a
            // write, HOLD raises cs before RECOVER drops we, so the responder
            // never sees a falling we with cs low during a write.
            case (next_state)
                ST_IDLE: begin
                    bus_cs   <= 1'b1;
                    bus_we   <= 1'b0;
                    drive_en <= 1'b0;
                end
                ST_PREP: begin
                    bus_cs   <= 1'b1;
                    bus_we   <= 1'b1;
                    drive_en <= 1'b0;
                end
                ST_SETUP: begin
                    bus_cs   <= 1'b0;
                    bus_we   <= !eff_we;
                    drive_en <= eff_we;
                end
                ST_STROBE: begin
                    bus_cs   <= 1'b0;
                    bus_we   <= eff_we;
                    drive_en <= eff_we;
                end
                ST_HOLD: begin
                    bus_cs   <= 1'b1;
                    bus_we   <= eff_we;
                    drive_en <= eff_we;
                end
                ST_RECOVER: begin
                    bus_cs   <= 1'b1;
                    bus_we   <= 1'b0;
                    drive_en <= 1'b0;
                end
                default: begin
                    bus_cs   <= 1'b1;
                    bus_we   <= 1'b0;
                    drive_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus_data = drive_en ? lat_wdata : {DATA_W{1'bz}};

endmodule
